// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - main sequencing state machine for the multicycle ARM core
//
// Steps the shared datapath through fetch, decode, address generation,
// memory access, execute and writeback. FETCH, MEMREAD and MEMWRITE wait
// for MemReady, so the core can run against variable-latency memory.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   reset      in   1  synchronous, active-low; forces FETCH
//   Op         in   2  Instr[27:26]
//   Funct      in   6  Instr[25:20]; bit 5 = I, bit 0 = L/S
//   MemReady   in   1  memory completed the current access this cycle
//   IRWrite    out  1  latch instruction register
//   AdrSrc     out  1  0: PC, 1: ALUOut drives memory address
//   ALUSrcA    out  2  00: reg A, 01: PC, 10: ALUOut
//   ALUSrcB    out  2  00: WriteData, 01: ExtImm, 10: constant 4
//   ResultSrc  out  2  00: ALUOut, 01: Data, 10: ALUResult
//   NextPC     out  1  PC update request
//   RegW       out  1  register write request
//   MemW       out  1  memory write request
//   Branch     out  1  branch request
//   ALUOp      out  1  0: add, 1: decode from Funct
//   State      out  4  current state code
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Raw (ungated) write enables; reset masking is applied at the ports.
  logic ir_write_raw;
  logic next_pc_raw;
  logic reg_w_raw;
  logic mem_w_raw;
  logic branch_raw;

  // Only the I and L/S bits steer sequencing; the rest belong to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        state_d = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;  // undefined opcode: drop instruction
        endcase
      end
      S_MEMADR: begin
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        state_d = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;  // illegal codes recover in one edge
      end
    endcase
  end

  // Output decode (Moore, except FETCH's IRWrite/NextPC follow MemReady)
  always_comb begin
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    branch_raw   = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUOp        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = MemReady;
        next_pc_raw  = MemReady;
      end
      S_DECODE: begin
        // PC+8 computed here for instructions that read R15
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        mem_w_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b00;
        ALUOp   = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        reg_w_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch_raw = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write enables are masked combinationally so an in-flight store or
  // writeback is cut off in the same cycle reset is asserted.
  assign IRWrite = ir_write_raw & reset;
  assign NextPC  = next_pc_raw  & reset;
  assign RegW    = reg_w_raw    & reset;
  assign MemW    = mem_w_raw    & reset;
  assign Branch  = branch_raw   & reset;
  assign State   = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// tb/tb_mainfsm.sv - self-checking bench for mainfsm
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [3:0] State;

  int n_cmp;
  int n_fail;

  logic [16:0] exp_q[$];
  string       tag_q[$];

  mainfsm dut (
    .clk      (clk),
    .reset    (reset),
    .Op       (Op),
    .Funct    (Funct),
    .MemReady (MemReady),
    .IRWrite  (IRWrite),
    .AdrSrc   (AdrSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ResultSrc(ResultSrc),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .Branch   (Branch),
    .ALUOp    (ALUOp),
    .State    (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for a given state, built from the state/output table.
  // Packing: {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
  //           NextPC, RegW, MemW, Branch, ALUOp}
  function automatic logic [16:0] model(input logic [3:0] st, input logic mr, input logic rst);
    logic       irw, adr, npc, rw, mw, br, aop;
    logic [1:0] sa, sb, rs;
    irw = 0; adr = 0; npc = 0; rw = 0; mw = 0; br = 0; aop = 0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (st)
      4'd0: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; irw = mr & rst; npc = mr & rst; end
      4'd1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd2: begin sb = 2'b01; end
      4'd3: begin adr = 1; end
      4'd4: begin rs = 2'b01; rw = rst; end
      4'd5: begin adr = 1; mw = rst; end
      4'd6: begin aop = 1; end
      4'd7: begin sb = 2'b01; aop = 1; end
      4'd8: begin rw = rst; end
      4'd9: begin sb = 2'b01; rs = 2'b10; br = rst; end
      default: begin end
    endcase
    return {st, irw, adr, sa, sb, rs, npc, rw, mw, br, aop};
  endfunction

  // One cycle: drive inputs after the falling edge, push the expectation,
  // pop and compare once outputs settle, then move to the next falling edge.
  task automatic step(input logic [1:0] op, input logic [5:0] funct, input logic mr,
                      input logic rst, input logic [3:0] exp_state, input string tag);
    logic [16:0] got;
    logic [16:0] exp;
    string       t;
    Op = op; Funct = funct; MemReady = mr; reset = rst;
    exp_q.push_back(model(exp_state, mr, rst));
    tag_q.push_back(tag);
    #1;
    got = {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};
    exp = exp_q.pop_front();
    t   = tag_q.pop_front();
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%05h expected=%05h", t, got, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    Op = 2'b00; Funct = 6'b001000; MemReady = 1'b1; reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held two cycles with MemReady=1: all enables forced low
    step(2'b00, 6'b001000, 1'b1, 1'b0, 4'd0, "reset_c1");
    step(2'b00, 6'b001000, 1'b1, 1'b0, 4'd0, "reset_c2");

    // ADD register: 0,1,6,8,0
    step(2'b00, 6'b001000, 1'b1, 1'b1, 4'd0, "add_fetch");
    step(2'b00, 6'b001000, 1'b1, 1'b1, 4'd1, "add_decode");
    step(2'b00, 6'b001000, 1'b1, 1'b1, 4'd6, "add_executer");
    step(2'b00, 6'b001000, 1'b1, 1'b1, 4'd8, "add_aluwb");

    // LDR with 3 wait cycles in MEMREAD: 0,1,2,3,3,3,3,4,0
    step(2'b01, 6'b011001, 1'b1, 1'b1, 4'd0, "ldr_fetch");
    step(2'b01, 6'b011001, 1'b0, 1'b1, 4'd1, "ldr_decode_mr0");
    step(2'b01, 6'b011001, 1'b0, 1'b1, 4'd2, "ldr_memadr_mr0");
    step(2'b01, 6'b011001, 1'b0, 1'b1, 4'd3, "ldr_memread_w1");
    step(2'b01, 6'b011001, 1'b0, 1'b1, 4'd3, "ldr_memread_w2");
    step(2'b01, 6'b011001, 1'b0, 1'b1, 4'd3, "ldr_memread_w3");
    step(2'b01, 6'b011001, 1'b1, 1'b1, 4'd3, "ldr_memread_go");
    step(2'b01, 6'b011001, 1'b1, 1'b1, 4'd4, "ldr_memwb");

    // STR with 2 fetch wait cycles: 0,0,0,1,2,5,0
    step(2'b01, 6'b011000, 1'b0, 1'b1, 4'd0, "str_fetch_w1");
    step(2'b01, 6'b011000, 1'b0, 1'b1, 4'd0, "str_fetch_w2");
    step(2'b01, 6'b011000, 1'b1, 1'b1, 4'd0, "str_fetch_go");
    step(2'b01, 6'b011000, 1'b1, 1'b1, 4'd1, "str_decode");
    step(2'b01, 6'b011000, 1'b1, 1'b1, 4'd2, "str_memadr");
    step(2'b01, 6'b011000, 1'b1, 1'b1, 4'd5, "str_memwrite");

    // Branch: 0,1,9,0 (MemReady low in DECODE/BRANCH must not stall)
    step(2'b10, 6'b000000, 1'b1, 1'b1, 4'd0, "b_fetch");
    step(2'b10, 6'b000000, 1'b0, 1'b1, 4'd1, "b_decode");
    step(2'b10, 6'b000000, 1'b0, 1'b1, 4'd9, "b_branch");

    // Undefined Op=11: 0,1,0
    step(2'b11, 6'b111111, 1'b1, 1'b1, 4'd0, "undef_fetch");
    step(2'b11, 6'b111111, 1'b1, 1'b1, 4'd1, "undef_decode");

    // STR interrupted by reset in MEMWRITE, then ADD immediate 0,1,7,8,0
    step(2'b01, 6'b011000, 1'b1, 1'b1, 4'd0, "str2_fetch");
    step(2'b01, 6'b011000, 1'b1, 1'b1, 4'd1, "str2_decode");
    step(2'b01, 6'b011000, 1'b0, 1'b1, 4'd2, "str2_memadr");
    step(2'b01, 6'b011000, 1'b0, 1'b1, 4'd5, "str2_memwrite_wait");
    step(2'b01, 6'b011000, 1'b0, 1'b0, 4'd5, "str2_reset_memw_drop");
    step(2'b00, 6'b101000, 1'b1, 1'b1, 4'd0, "addi_fetch");
    step(2'b00, 6'b101000, 1'b1, 1'b1, 4'd1, "addi_decode");
    step(2'b00, 6'b101000, 1'b1, 1'b1, 4'd7, "addi_executei");
    step(2'b00, 6'b101000, 1'b1, 1'b1, 4'd8, "addi_aluwb");
    step(2'b00, 6'b101000, 1'b0, 1'b1, 4'd0, "final_fetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
